// File: rtl/fpga_tcam_pkg.sv
// Shared types and slice-geometry helpers for the pipelined ternary CAM.
package fpga_tcam_pkg;

  typedef enum logic {WRITE = 1'b0, DELETE = 1'b1} tcam_op_e;
  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} tcam_state_e;

  function automatic int unsigned tcam_slices(input int unsigned width, input int unsigned l);
    return (width + l - 1) / l;
  endfunction

  function automatic int unsigned tcam_pad_width(input int unsigned width, input int unsigned l);
    return tcam_slices(width, l) * l;
  endfunction

endpackage

// File: rtl/tcam_slice_ram.sv
// One key slice: 2^L rows x DEPTH columns, registered read-first port, per-column write enable.
module tcam_slice_ram #(
  parameter int unsigned L     = 4,
  parameter int unsigned DEPTH = 64
) (
  input  logic             clk,
  input  logic [L-1:0]     i_raddr,
  output logic [DEPTH-1:0] o_rdata,
  input  logic [L-1:0]     i_waddr,
  input  logic [DEPTH-1:0] i_we,
  input  logic [DEPTH-1:0] i_wdata
);

  localparam int unsigned ROWS = 2**L;

  logic [DEPTH-1:0] r_mem [ROWS];

  always_ff @(posedge clk) begin
    o_rdata <= r_mem[i_raddr];
    if (|i_we) begin
      r_mem[i_waddr] <= (r_mem[i_waddr] & ~i_we) | (i_wdata & i_we);
    end
  end

endmodule

// File: rtl/fpga_tcam_pq.sv
// Pipelined ternary CAM: row-sweep programming, 2-cycle lookup, lowest-index priority.
// Optional multi-hit outputs (r_multi, r_count) with `FPGA_TCAM_MULTI_HIT_EN.
module fpga_tcam_pq
  import fpga_tcam_pkg::*;
#(
  parameter  int unsigned DEPTH = 64,
  parameter  int unsigned WIDTH = 36,
  parameter  int unsigned L     = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic             w_op,
  input  logic [AW-1:0]    w_addr,
  input  logic [WIDTH-1:0] w_patt,
  input  logic [WIDTH-1:0] w_mask,
  output logic             w_done,
  input  logic             m_valid,
  output logic             m_ready,
  input  logic [WIDTH-1:0] m_key,
  output logic             r_valid,
  output logic             r_match,
  output logic [AW-1:0]    r_addr
`ifdef FPGA_TCAM_MULTI_HIT_EN
  ,
  output logic                         r_multi,
  output logic [$clog2(DEPTH+1)-1:0]   r_count
`endif
);

  localparam int unsigned S        = tcam_slices(WIDTH, L);
  localparam int unsigned PW       = tcam_pad_width(WIDTH, L);
  localparam int unsigned ROWS     = 2**L;
  localparam logic [L-1:0] ROW_LAST = L'(ROWS - 1);
  localparam logic [L-1:0] ROW_DONE = L'(ROWS - 2);
`ifdef FPGA_TCAM_MULTI_HIT_EN
  localparam int unsigned CW       = $clog2(DEPTH + 1);
`endif

  tcam_state_e      r_state, w_state_nxt;
  logic [L-1:0]     r_row;
  logic [AW-1:0]    r_waddr;
  logic [PW-1:0]    r_patt, r_mask;
  logic [DEPTH-1:0] r_vld, r_snap;
  logic             r_s1_valid, r_w_done;

  logic             w_wr_acc, w_del_acc, w_m_acc, w_sweep, w_sweep_last;
  logic [PW-1:0]    w_key_pad, w_mask_pad;
  logic [DEPTH-1:0] w_we, w_hit;
  logic [DEPTH-1:0] w_rows [S];
  logic [AW-1:0]    w_enc;
`ifdef FPGA_TCAM_MULTI_HIT_EN
  logic [CW-1:0]    w_cnt;
`endif

  // Pad bits: key reads as 0, mask reads as don't-care, so padding never blocks a hit.
  assign w_key_pad  = PW'(m_key);
  assign w_mask_pad = ~PW'(~w_mask);
  assign w_we       = w_sweep ? (DEPTH'(1) << r_waddr) : '0;
  assign w_done     = r_w_done;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_wr_acc) w_state_nxt = SWEEP;
      SWEEP:   if (r_row == ROW_LAST) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A pending WRITE blocks the match port so it wins arbitration.
  always_comb begin
    w_ready      = (r_state == IDLE);
    m_ready      = (r_state == IDLE) && !(w_valid && (tcam_op_e'(w_op) == WRITE));
    w_wr_acc     = (r_state == IDLE) && w_valid && (tcam_op_e'(w_op) == WRITE);
    w_del_acc    = (r_state == IDLE) && w_valid && (tcam_op_e'(w_op) == DELETE);
    w_m_acc      = m_valid && m_ready;
    w_sweep      = (r_state == SWEEP);
    w_sweep_last = w_sweep && (r_row == ROW_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row    <= '0;
      r_vld    <= '0;
      r_w_done <= 1'b0;
    end else begin
      r_w_done <= w_del_acc || (w_sweep && (r_row == ROW_DONE));
      if (w_wr_acc) begin
        r_row          <= '0;
        r_waddr        <= w_addr;
        r_patt         <= PW'(w_patt);
        r_mask         <= w_mask_pad;
        r_vld[w_addr]  <= 1'b0;
      end else if (w_sweep) begin
        r_row <= r_row + L'(1);
      end
      if (w_del_acc)    r_vld[w_addr]  <= 1'b0;
      if (w_sweep_last) r_vld[r_waddr] <= 1'b1;
    end
  end

  for (genvar s = 0; s < S; s++) begin : g_slice
    logic w_bit;
    assign w_bit = ((r_row ^ r_patt[s*L +: L]) & ~r_mask[s*L +: L]) == '0;

    tcam_slice_ram #(.L(L), .DEPTH(DEPTH)) u_ram (
      .clk     (clk),
      .i_raddr (w_key_pad[s*L +: L]),
      .o_rdata (w_rows[s]),
      .i_waddr (r_row),
      .i_we    (w_we),
      .i_wdata ({DEPTH{w_bit}})
    );
  end

  // Stage 0: RAM row addresses come straight from the key; the valid vector is snapshotted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_snap     <= '0;
    end else begin
      r_s1_valid <= w_m_acc;
      if (w_m_acc) r_snap <= r_vld;
    end
  end

  always_comb begin
    w_hit = r_snap & {DEPTH{r_s1_valid}};
    for (int s = 0; s < int'(S); s++) w_hit = w_hit & w_rows[s];
    w_enc = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (w_hit[i]) w_enc = AW'(i);
    end
`ifdef FPGA_TCAM_MULTI_HIT_EN
    w_cnt = '0;
    for (int i = 0; i < int'(DEPTH); i++) w_cnt = w_cnt + CW'(w_hit[i]);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_match <= 1'b0;
      r_addr  <= '0;
`ifdef FPGA_TCAM_MULTI_HIT_EN
      r_multi <= 1'b0;
      r_count <= '0;
`endif
    end else begin
      r_valid <= r_s1_valid;
      r_match <= |w_hit;
      r_addr  <= w_enc;
`ifdef FPGA_TCAM_MULTI_HIT_EN
      r_multi <= (w_cnt > CW'(1));
      r_count <= w_cnt;
`endif
    end
  end

endmodule

// File: tb/tb_fpga_tcam_pq.sv
// Directed self-checking bench for fpga_tcam_pq (36-bit instance plus a padded 10-bit instance).
module tb_fpga_tcam_pq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        w_valid, w_ready, w_op, w_done;
  logic [5:0]  w_addr;
  logic [35:0] w_patt, w_mask, m_key;
  logic        m_valid, m_ready, r_valid, r_match;
  logic [5:0]  r_addr;

  logic        n_w_valid, n_w_ready, n_w_op, n_w_done;
  logic [5:0]  n_w_addr;
  logic [9:0]  n_w_patt, n_w_mask, n_m_key;
  logic        n_m_valid, n_m_ready, n_r_valid, n_r_match;
  logic [5:0]  n_r_addr;
`ifdef FPGA_TCAM_MULTI_HIT_EN
  logic        r_multi, n_r_multi;
  logic [6:0]  r_count, n_r_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fpga_tcam_pq #(.DEPTH(64), .WIDTH(36), .L(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .w_valid(w_valid), .w_ready(w_ready), .w_op(w_op), .w_addr(w_addr),
    .w_patt(w_patt), .w_mask(w_mask), .w_done(w_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_key(m_key),
    .r_valid(r_valid), .r_match(r_match), .r_addr(r_addr)
`ifdef FPGA_TCAM_MULTI_HIT_EN
    , .r_multi(r_multi), .r_count(r_count)
`endif
  );

  fpga_tcam_pq #(.DEPTH(64), .WIDTH(10), .L(4)) u_dut_n (
    .clk(clk), .rst_n(rst_n),
    .w_valid(n_w_valid), .w_ready(n_w_ready), .w_op(n_w_op), .w_addr(n_w_addr),
    .w_patt(n_w_patt), .w_mask(n_w_mask), .w_done(n_w_done),
    .m_valid(n_m_valid), .m_ready(n_m_ready), .m_key(n_m_key),
    .r_valid(n_r_valid), .r_match(n_r_match), .r_addr(n_r_addr)
`ifdef FPGA_TCAM_MULTI_HIT_EN
    , .r_multi(n_r_multi), .r_count(n_r_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue a WRITE at cycle T; returns at T+17 with w_done latency and handshake stall checked.
  task automatic do_write(input string tag, input logic [5:0] a, input logic [35:0] p,
                          input logic [35:0] m);
    int done_at;
    bit rdy_low;
    w_valid = 1'b1; w_op = 1'b0; w_addr = a; w_patt = p; w_mask = m;
    cyc();
    w_valid = 1'b0;
    done_at = -1;
    rdy_low = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      if (w_done && done_at < 0) done_at = k;
      if (w_ready || m_ready) rdy_low = 1'b0;
      cyc();
    end
    check({tag, "_done_lat"}, 64'(done_at), 64'd16);
    check({tag, "_rdy_low"}, 64'(rdy_low), 64'd1);
    check({tag, "_ready_back"}, {62'd0, w_ready, m_ready}, 64'd3);
  endtask

  task automatic do_match(input string tag, input logic [35:0] k, input logic exp_m,
                          input logic [5:0] exp_a);
    m_valid = 1'b1; m_key = k;
    cyc();
    m_valid = 1'b0;
    cyc();
    check({tag, "_valid"}, 64'(r_valid), 64'd1);
    check({tag, "_match"}, 64'(r_match), 64'(exp_m));
    check({tag, "_addr"}, 64'(r_addr), 64'(exp_a));
  endtask

  task automatic n_write(input string tag, input logic [5:0] a, input logic [9:0] p,
                         input logic [9:0] m);
    int done_at;
    n_w_valid = 1'b1; n_w_op = 1'b0; n_w_addr = a; n_w_patt = p; n_w_mask = m;
    cyc();
    n_w_valid = 1'b0;
    done_at = -1;
    for (int k = 1; k <= 16; k++) begin
      if (n_w_done && done_at < 0) done_at = k;
      cyc();
    end
    check({tag, "_done_lat"}, 64'(done_at), 64'd16);
    check({tag, "_ready_back"}, {62'd0, n_w_ready, n_m_ready}, 64'd3);
  endtask

  task automatic n_match(input string tag, input logic [9:0] k, input logic exp_m,
                         input logic [5:0] exp_a);
    n_m_valid = 1'b1; n_m_key = k;
    cyc();
    n_m_valid = 1'b0;
    cyc();
    check({tag, "_valid"}, 64'(n_r_valid), 64'd1);
    check({tag, "_match"}, 64'(n_r_match), 64'(exp_m));
    check({tag, "_addr"}, 64'(n_r_addr), 64'(exp_a));
  endtask

  logic [35:0] s_keys [8];
  logic        s_exp_m [8];
  logic [5:0]  s_exp_a [8];
  bit          flag;
  int          done_at;

  initial begin
    s_keys  = '{36'h1234, 36'hABC, 36'h1235, 36'hABC, 36'h1234, 36'h0, 36'hABD, 36'h1234};
    s_exp_m = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    s_exp_a = '{6'h10, 6'd7, 6'd0, 6'd7, 6'h10, 6'd0, 6'd0, 6'h10};

    rst_n = 1'b0;
    w_valid = 1'b0; w_op = 1'b0; w_addr = '0; w_patt = '0; w_mask = '0;
    m_valid = 1'b0; m_key = '0;
    n_w_valid = 1'b0; n_w_op = 1'b0; n_w_addr = '0; n_w_patt = '0; n_w_mask = '0;
    n_m_valid = 1'b0; n_m_key = '0;
    repeat (3) cyc();
    check("rst_w_ready", 64'(w_ready), 64'd1);
    check("rst_m_ready", 64'(m_ready), 64'd1);
    check("rst_w_done", 64'(w_done), 64'd0);
    check("rst_r_out", {61'd0, r_valid, r_match, |r_addr}, 64'd0);
`ifdef FPGA_TCAM_MULTI_HIT_EN
    check("rst_multi", {56'd0, r_multi, r_count}, 64'd0);
`endif
    rst_n = 1'b1;
    cyc();

    // Single exact entry; first match lands on the first cycle after the sweep.
    do_write("wr10", 6'h10, 36'h1234, 36'h0);
    do_match("m1234", 36'h1234, 1'b1, 6'h10);
    do_match("m1235", 36'h1235, 1'b0, 6'h0);

    // Masked entry at a lower index wins priority.
    do_write("wr5", 6'd5, 36'h1230, 36'hF);
    do_match("m1234_two", 36'h1234, 1'b1, 6'd5);
`ifdef FPGA_TCAM_MULTI_HIT_EN
    check("multi_flag", 64'(r_multi), 64'd1);
    check("multi_count", 64'(r_count), 64'd2);
`endif
    do_match("m1235_mask", 36'h1235, 1'b1, 6'd5);
    do_match("m1300", 36'h1300, 1'b0, 6'd0);

    // DELETE with a same-cycle match, then a back-to-back match.
    w_valid = 1'b1; w_op = 1'b1; w_addr = 6'd5;
    m_valid = 1'b1; m_key = 36'h1234;
    #1;
    check("del_m_ready", 64'(m_ready), 64'd1);
    cyc();
    w_valid = 1'b0;
    check("del_done", 64'(w_done), 64'd1);
    cyc();
    m_valid = 1'b0;
    check("del_done_pulse", 64'(w_done), 64'd0);
    check("del_pre_addr", {57'd0, r_valid, r_addr}, {57'd0, 1'b1, 6'd5});
    cyc();
    check("del_post_addr", {56'd0, r_valid, r_match, r_addr}, {56'd0, 1'b1, 1'b1, 6'h10});
    cyc();
    check("del_idle", 64'(r_valid), 64'd0);

    // WRITE and match requested together: write wins, then an 8-deep match stream.
    w_valid = 1'b1; w_op = 1'b0; w_addr = 6'd7; w_patt = 36'hABC; w_mask = 36'h0;
    m_valid = 1'b1; m_key = 36'h1234;
    #1;
    check("arb_m_ready", {62'd0, w_ready, m_ready}, 64'd2);
    cyc();
    w_valid = 1'b0;
    flag = 1'b1;
    done_at = -1;
    for (int k = 1; k <= 16; k++) begin
      if (m_ready || r_valid) flag = 1'b0;
      if (w_done && done_at < 0) done_at = k;
      cyc();
    end
    check("arb_stall", 64'(flag), 64'd1);
    check("arb_done_lat", 64'(done_at), 64'd16);
    flag = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      m_valid = (i < 8);
      if (i < 8) m_key = s_keys[i];
      if (i < 8 && !m_ready) flag = 1'b0;
      if (i >= 2 && i < 10) begin
        check($sformatf("stream%0d", i - 2), {56'd0, r_valid, r_match, r_addr},
              {56'd0, 1'b1, s_exp_m[i-2], s_exp_a[i-2]});
      end else begin
        check($sformatf("stream_gap%0d", i), 64'(r_valid), 64'd0);
      end
      cyc();
    end
    check("stream_ready", 64'(flag), 64'd1);

    // Reset in the middle of a sweep aborts it.
    w_valid = 1'b1; w_op = 1'b0; w_addr = 6'd9; w_patt = 36'h5555; w_mask = 36'h0;
    cyc();
    w_valid = 1'b0;
    repeat (7) cyc();
    rst_n = 1'b0;
    cyc();
    check("mid_rst_ready", {62'd0, w_ready, m_ready}, 64'd3);
    check("mid_rst_outs", {61'd0, w_done, r_valid, r_match}, 64'd0);
    check("mid_rst_addr", 64'(r_addr), 64'd0);
    rst_n = 1'b1;
    flag = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (w_done) flag = 1'b0;
      cyc();
    end
    check("abort_no_done", 64'(flag), 64'd1);
    do_match("post_rst_1234", 36'h1234, 1'b0, 6'd0);
    do_match("post_rst_5555", 36'h5555, 1'b0, 6'd0);

    // Reset with a match in flight drops the result.
    do_write("wr3", 6'd3, 36'h1234, 36'h0);
    m_valid = 1'b1; m_key = 36'h1234;
    cyc();
    m_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    check("flight_rst_a", 64'(r_valid), 64'd0);
    rst_n = 1'b1;
    cyc();
    check("flight_rst_b", 64'(r_valid), 64'd0);

    // Padded 10-bit instance (3 slices of 4 bits).
    n_write("nwr2a", 6'h2A, 10'h3FF, 10'h0);
    n_match("n3ff", 10'h3FF, 1'b1, 6'h2A);
    n_match("n3fe", 10'h3FE, 1'b0, 6'h0);
    n_write("nwr1", 6'd1, 10'h000, 10'h1FF);
    n_match("n1ff", 10'h1FF, 1'b1, 6'd1);
    n_match("n3ff_b", 10'h3FF, 1'b1, 6'h2A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpga_tcam_pq.md
# fpga_tcam_pq

Pipelined, parametrised ternary CAM for FPGA fabric, the next generation of the team's `fpga_cam`. Each key is split into L-bit slices. Each slice is a 2^L-row × DEPTH-bit lookup memory. A write runs a row-sweep FSM that programs every slice. A lookup reads one row per slice, ANDs the rows with a valid vector and priority-encodes the result. Over its predecessor it adds valid/ready handshakes, a pipelined back-to-back match path, single-cycle delete, per-entry valid bits and automatic padding of WIDTH to a slice multiple.

## Interface
- DEPTH, 64, number of entries
- WIDTH, 36, key width in bits
- L, 4, bits per slice; S = ceil(WIDTH/L) slices; sweep length 2^L cycles
- AW, $clog2(DEPTH), address width (derived, not overridden)
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  synchronous, active-low reset
- w_valid  in  1  write-port request
- w_ready  out  1  write port can accept
- w_op  in  1  0 = WRITE, 1 = DELETE
- w_addr  in  AW  target entry
- w_patt  in  WIDTH  pattern
- w_mask  in  WIDTH  1 = don't-care bit
- w_done  out  1  one-cycle pulse when a WRITE or DELETE takes effect
- m_valid  in  1  match request
- m_ready  out  1  match port can accept
- m_key  in  WIDTH  search key
- r_valid  out  1  result strobe; no backpressure
- r_match  out  1  at least one valid entry hit
- r_addr  out  AW  lowest-index hit; 0 on miss

## Operation
- FSM states: IDLE and SWEEP.
- IDLE, accepted WRITE → SWEEP. Row counter = 0. Valid[w_addr] cleared. Pattern and mask latched; pad bits forced to mask = 1.
- SWEEP, per cycle: for each slice s, bit w_addr of row r = (((r ^ patt_s) & ~mask_s) == 0). Row counter increments.
- SWEEP at r = 2^L−1 → IDLE. Valid[w_addr] set. w_done pulses.
- DELETE is accepted in IDLE. Valid[w_addr] is cleared the next cycle. w_done pulses that same cycle. Memory is untouched.
- w_ready = (state == IDLE).
- m_ready = (state == IDLE) & ~(w_valid & w_op == WRITE).
- A pending WRITE beats a match in the same cycle.
- DELETE and match may be accepted in the same cycle. That match sees the pre-delete table.
- Match stage 0, accept: slice row addresses and a valid-vector snapshot are registered.
- Match stage 1: slice rows are read; the read-first memory returns content from before any same-edge write.
- Match stage 2: AND of the S rows and the snapshot; priority encode; registered outputs.
- Results return in request order. One request per cycle is sustained while m_ready is high.
- Reset clears: valid vector, FSM state, pipeline valids and all outputs. Memory contents are not cleared; the valid bits mask them.

## Timing
- Reset values: w_ready = 1, m_ready = 1, w_done = 0, r_valid = 0, r_match = 0, r_addr = 0. Multi-hit outputs (see Configuration) = 0.
- Match accepted at cycle T → r_valid at T+2.
- WRITE accepted at T → w_ready and m_ready low for T+1..T+2^L. w_done at T+2^L. A match accepted at T+2^L+1 or later sees the new entry.
- DELETE accepted at T → w_done at T+1. Matches accepted at T+1 or later miss the entry.
- Matches already in flight when a WRITE is accepted complete normally and see the old entry state.
- Rewriting a live address invalidates it for the whole sweep.
- Reset during SWEEP aborts the sweep. The entry stays invalid and no w_done is issued.
- Reset with matches in flight drops them; no r_valid is issued.

## Configuration
- `FPGA_TCAM_MULTI_HIT_EN` defined:
  - adds r_multi (out, 1): more than one hit;
  - adds r_count (out, $clog2(DEPTH+1)): popcount of the hit vector;
  - both are registered alongside r_match with the same latency.
- Not defined: these ports and the popcount logic are absent. Everything else is identical.

## Structure
- Package `fpga_tcam_pkg` holds:
  - the op enum `tcam_op_e` (WRITE, DELETE);
  - the state enum `tcam_state_e` (IDLE, SWEEP);
  - the function computing S and the padded width.
- Sub-module `tcam_slice_ram`: one 2^L × DEPTH read-first memory with a single-bit write enable per column. It is instantiated S times.
- The priority encoder and popcount stay inline.

## Test plan
- DEPTH 64, WIDTH 36, L 4. WRITE addr 0x10, patt 0x1234, mask 0 → w_done 16 cycles after accept. Match 0x1234 → r_match = 1, r_addr = 0x10 at T+2. Match 0x1235 → r_match = 0.
- WRITE addr 5, patt 0x1230, mask 0xF, plus the entry above. Match 0x1234 → r_addr = 5. With the macro: r_multi = 1, r_count = 2.
- DELETE addr 5 and match 0x1234 in the same cycle → r_addr = 5. The next match → r_addr = 0x10, and w_done pulses at T+1.
- Hold w_valid (WRITE) and m_valid together while idle → write accepted first. m_ready stays low for 16 cycles. Then 8 back-to-back matches → 8 consecutive r_valid, in order.
- Pull rst_n low at sweep cycle 8 for one cycle → no w_done. Match 0x1234 → miss. All outputs at their reset values during reset.
- WIDTH 10, L 4 (S = 3, padded). WRITE patt 0x3FF, mask 0 → match 0x3FF hits; match 0x3FE misses.
